seg7_scan_driver: RTL and testbench

Hardware-scanned seven-segment display driver on the memory bus, directly downstream of the software BCD control register. It holds a 16-bit hex display value and autonomously multiplexes four digits. Its output uses the same 12-bit word format as the BCD control register. When scanning is disabled, it passes the software-written BCD control word straight through to the display pins.

---
 rtl/seg7_scan_driver.sv | 117 +++++++++++
 tb/tb_seg7_scan_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Memory-mapped 4-digit hex seven-segment scanner with BCD-word passthrough when disabled.
// Optional leading-zero blanking is compiled in with `define SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] MemBus_Read_Data,
  input  logic [11:0] bcd_sw,
  output logic [11:0] disp_out
);
  localparam logic [31:0] DATA_ADDR = 32'h4000_0014;
  localparam logic [31:0] CTRL_ADDR = 32'h4000_0018;
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

  logic [19:0]   data_q, data_d;
  logic          en_q, en_d;
  logic [3:0]    mask_q, mask_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   disp_q, disp_d;

  logic       data_wr, ctrl_wr;
  logic [3:0] digit;
  logic       dp_k, lzb_blank;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       unused_wdata;

  assign data_wr      = MemWrite && (MemBus_Address == DATA_ADDR);
  assign ctrl_wr      = MemWrite && (MemBus_Address == CTRL_ADDR);
  assign unused_wdata = ^MemBus_Write_Data[31:20];

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0: seg_decode = 7'h40;  4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;  4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;  4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;  4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;  4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;  4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;  4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;  default: seg_decode = 7'h0E;
    endcase
  endfunction

  // Register file and scan counters; a CTRL write that sets enable restarts the frame.
  always_comb begin
    data_d  = data_wr ? MemBus_Write_Data[19:0] : data_q;
    en_d    = ctrl_wr ? MemBus_Write_Data[0]    : en_q;
    mask_d  = ctrl_wr ? MemBus_Write_Data[7:4]  : mask_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    if (!en_d || ctrl_wr) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (presc_q == TC) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_comb begin
    digit = data_q[{idx_q, 2'b00} +: 4];
    dp_k  = data_q[16 + 32'(idx_q)];
    seg   = seg_decode(digit);
    anode = ~(4'b0001 << idx_q);
`ifdef SEG7_LZB_EN
    // Digit k is a leading zero when it and every more significant digit are 0.
    case (idx_q)
      2'd3:    lzb_blank = (data_q[15:12] == 4'h0);
      2'd2:    lzb_blank = (data_q[15:8]  == 8'h00);
      2'd1:    lzb_blank = (data_q[15:4]  == 12'h000);
      default: lzb_blank = 1'b0;
    endcase
    lzb_blank = lzb_blank && !dp_k;
`else
    lzb_blank = 1'b0;
`endif
    if (!en_q)                          disp_d = bcd_sw;
    else if (mask_q[idx_q] || lzb_blank) disp_d = 12'hFFF;
    else                                disp_d = {anode, ~dp_k, seg};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      en_q    <= 1'b0;
      mask_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      disp_q  <= 12'h000;
    end else begin
      data_q  <= data_d;
      en_q    <= en_d;
      mask_q  <= mask_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    MemBus_Read_Data = 32'h0;
    if (MemRead && MemBus_Address == DATA_ADDR) MemBus_Read_Data = {12'h0, data_q};
    else if (MemRead && MemBus_Address == CTRL_ADDR) MemBus_Read_Data = {24'h0, mask_q, 3'b000, en_q};
  end

  assign disp_out = disp_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model predicts every
// registered display word; a monitor pops and compares one prediction per clock.
module tb_seg7_scan_driver;
  localparam int DIV = 4;
  localparam logic [31:0] A_DATA = 32'h4000_0014;
  localparam logic [31:0] A_CTRL = 32'h4000_0018;
  localparam logic [31:0] A_OTHER = 32'h4000_001C;

  logic        clk = 1'b0, reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] MemBus_Address = '0, MemBus_Write_Data = '0;
  logic [31:0] MemBus_Read_Data;
  logic [11:0] bcd_sw = '0;
  logic [11:0] disp_out;

  int checks = 0, errors = 0;
  logic [11:0] exp_q[$];

  // Reference state: register contents plus cycles elapsed since the frame (re)started.
  logic [19:0] m_data;
  logic        m_en;
  logic [3:0]  m_mask;
  int          m_t;

  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [11:0] scan_1234 [4] = '{12'hE99, 12'hDB0, 12'hBA4, 12'h7F9};

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemBus_Address(MemBus_Address), .MemBus_Write_Data(MemBus_Write_Data),
    .MemBus_Read_Data(MemBus_Read_Data), .bcd_sw(bcd_sw), .disp_out(disp_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_data = '0; m_en = 1'b0; m_mask = '0; m_t = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == A_DATA) return {12'h0, m_data};
    if (a == A_CTRL) return {24'h0, m_mask, 3'b000, m_en};
    return 32'h0;
  endfunction

  function automatic logic [11:0] model_disp(input logic [11:0] sw);
    int k, hi;
    logic [3:0] d, an;
    logic dp;
    if (!m_en) return sw;
    k  = (m_t / DIV) % 4;
    d  = 4'((m_data >> (4 * k)) & 20'hF);
    dp = m_data[16 + k];
    if (m_mask[k]) return 12'hFFF;
`ifdef SEG7_LZB_EN
    hi = -1;
    for (int j = 0; j < 4; j++) if (((m_data >> (4 * j)) & 20'hF) != 0) hi = j;
    if (k > 0 && k > hi && !dp) return 12'hFFF;
`else
    hi = 0;
    if (hi != 0) return 12'hFFF;
`endif
    an = 4'hF;
    an[k] = 1'b0;
    return {an, ~dp, seg_tab[d]};
  endfunction

  function automatic void model_update(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    logic cw;
    cw = wr && (a == A_CTRL);
    if (wr && a == A_DATA) m_data = wd[19:0];
    if (cw) begin m_en = wd[0]; m_mask = wd[7:4]; end
    if (!m_en || cw) m_t = 0;
    else m_t = (m_t + 1) % (4 * DIV);
  endfunction

  // One clock: drive inputs, check readback, predict the next display word, advance the model.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [11:0] sw);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemBus_Address = a; MemBus_Write_Data = wd; bcd_sw = sw;
    #1;
    if (rd) check("readback", MemBus_Read_Data, model_read(a));
    exp_q.push_back(model_disp(sw));
    model_update(wr, a, wd);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [11:0] sw);
    step(1'b0, 1'b0, 32'h0, 32'h0, sw);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    MemWrite = 1'b0; MemRead = 1'b1; MemBus_Address = A_DATA;
    #1 check("reset_disp", {20'h0, disp_out}, 32'h0);
    check("reset_data", MemBus_Read_Data, 32'h0);
    MemBus_Address = A_CTRL;
    #1 check("reset_ctrl", MemBus_Read_Data, 32'h0);
    MemRead = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("disp_out", {20'h0, disp_out}, {20'h0, e});
      end
    end
  end

  initial begin : driver
    model_reset();
    #12;
    check("por_disp", {20'h0, disp_out}, 32'h0);
    do_reset();

    // Passthrough while disabled.
    idle(12'hA5C);
    check("pass_a5c", {20'h0, disp_out}, 32'hA5C);
    idle(12'h3F0);
    check("pass_3f0", {20'h0, disp_out}, 32'h3F0);

    // Scan 0x1234, then with digit 1 masked.
    step(1'b0, 1'b1, A_DATA, 32'h0000_1234, 12'h111);
    step(1'b0, 1'b1, A_CTRL, 32'h1, 12'h111);
    for (int i = 0; i < 16; i++) begin
      idle(12'h222);
      check("scan_1234", {20'h0, disp_out}, {20'h0, scan_1234[i / 4]});
    end
    step(1'b0, 1'b1, A_CTRL, 32'h21, 12'h0);
    for (int i = 0; i < 16; i++) begin
      idle(12'h0);
      check("scan_mask1", {20'h0, disp_out}, (i / 4 == 1) ? 32'hFFF : {20'h0, scan_1234[i / 4]});
    end

    // Leading-zero candidate pattern (checked through the model in either build).
    step(1'b0, 1'b1, A_DATA, 32'h0000_0087, 12'h0);
    step(1'b0, 1'b1, A_CTRL, 32'h1, 12'h0);
    repeat (16) idle(12'h0);
    step(1'b0, 1'b1, A_DATA, 32'h0001_0005, 12'h0);
    repeat (16) idle(12'h0);

    // Readback and enable restart mid-slot.
    step(1'b1, 1'b1, A_DATA, 32'hFFFF_FFFF, 12'h0);
    step(1'b1, 1'b0, A_DATA, 32'h0, 12'h0);
    check("rb_data", MemBus_Read_Data, 32'h000F_FFFF);
    step(1'b1, 1'b0, A_OTHER, 32'h0, 12'h0);
    repeat (6) idle(12'h0);
    step(1'b0, 1'b1, A_CTRL, 32'h1, 12'h0);
    for (int i = 0; i < DIV; i++) begin
      idle(12'h0);
      check("restart_d0", {20'h0, disp_out}, 32'hE0E);
    end
    idle(12'h0);
    check("restart_d1", {20'h0, disp_out}, 32'hD0E);

    // Disable mid-frame, reset mid-scan.
    step(1'b0, 1'b1, A_CTRL, 32'h0, 12'h5A5);
    idle(12'h777);
    check("disable_pass", {20'h0, disp_out}, 32'h777);
    step(1'b0, 1'b1, A_CTRL, 32'h1, 12'h0);
    repeat (5) idle(12'h0);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, wd;
      logic wr, rd;
      case ($urandom_range(0, 3))
        0: a = A_DATA;
        1: a = A_CTRL;
        2: a = A_OTHER;
        default: a = $urandom;
      endcase
      wd = $urandom;
      if (a == A_CTRL && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      wr = ($urandom_range(0, 99) < 6);
      rd = ($urandom_range(0, 3) == 0);
      step(rd, wr, a, wd, 12'($urandom));
      if (n == 900) do_reset();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
